// File: rtl/aes128_encrypt_core.sv
// rtl/aes128_encrypt_core.sv - iterative AES-128 encryption core, one round per clock
// Round keys are expanded on the fly alongside the state; no backpressure on either side.
module aes128_encrypt_core #(
  parameter int KEY_LEN       = 128,
  parameter int DATA_LEN      = 128,
  parameter int NUMS_OF_ROUND = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] plain_text,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  output logic                data_valid_out,
  output logic [DATA_LEN-1:0] cipher_text
);

  typedef enum logic {IDLE, RUN} fsm_t;

  // Forward S-box, byte b lives at bits [8b : 8b+7] of this ascending vector.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t                cs, ns;
  logic [KEY_LEN-1:0]  key_q;
  logic [KEY_LEN-1:0]  key_sel;
  logic [KEY_LEN-1:0]  rk_q;
  logic [DATA_LEN-1:0] state_q;
  logic [3:0]          round_q;
  logic                start, key_load, busy, last_round;

  logic [31:0]  rk_t, nk0, nk1, nk2, nk3;
  logic [127:0] next_rk, sb, sr, mc, round_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cs <= IDLE;
    else       cs <= ns;
  end

  always_comb begin
    ns = cs;
    case (cs)
      IDLE:    if (data_valid_in) ns = RUN;
      RUN:     if (last_round) ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  always_comb begin
    start      = (cs == IDLE) && data_valid_in;
    key_load   = (cs == IDLE) && key_valid_in;
    busy       = (cs == RUN);
    last_round = (cs == RUN) && (round_q == 4'(NUMS_OF_ROUND));
  end

  assign key_sel = key_valid_in ? cipher_key : key_q;

  always_comb begin
    rk_t    = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon(round_q), 24'h000000};
    nk0     = rk_q[127:96] ^ rk_t;
    nk1     = rk_q[95:64] ^ nk0;
    nk2     = rk_q[63:32] ^ nk1;
    nk3     = rk_q[31:0] ^ nk2;
    next_rk = {nk0, nk1, nk2, nk3};
  end

  // Byte i of the block sits at row i%4, column i/4 of the AES state.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++)
      sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    round_out = (last_round ? sr : mc) ^ next_rk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q          <= '0;
      rk_q           <= '0;
      state_q        <= '0;
      round_q        <= '0;
      cipher_text    <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= last_round;
      if (key_load) key_q <= cipher_key;
      if (start) begin
        state_q <= plain_text ^ key_sel;
        rk_q    <= key_sel;
        round_q <= 4'd1;
      end else if (busy) begin
        state_q <= round_out;
        rk_q    <= next_rk;
        round_q <= last_round ? 4'd0 : round_q + 4'd1;
        if (last_round) cipher_text <= round_out;
      end
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// tb/tb_aes128_encrypt_core.sv - randomized and known-answer bench for aes128_encrypt_core
// Reference AES is built from GF(2^8) arithmetic, including the S-box itself.
module tb_aes128_encrypt_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid_in;
  logic [127:0] plain_text;
  logic         key_valid_in;
  logic [127:0] cipher_key;
  logic         data_valid_out;
  logic [127:0] cipher_text;

  int errors = 0;
  int checks = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] stored_key;

  always #5 clk = ~clk;

  aes128_encrypt_core dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid_in  (data_valid_in),
    .plain_text     (plain_text),
    .key_valid_in   (key_valid_in),
    .cipher_key     (cipher_key),
    .data_valid_out (data_valid_out),
    .cipher_text    (cipher_text)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0]  inv;
    logic [15:0] bb;
    logic [7:0]  s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ 8'h63;
      for (int k = 1; k < 5; k++) begin
        bb = {inv, inv} << k;
        s  = s ^ bb[15:8];
      end
      sbox_tab[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_tab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = st[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_enc(input logic [127:0] pt, input logic [127:0] key, input logic with_key);
    plain_text    = pt;
    cipher_key    = key;
    data_valid_in = 1'b1;
    key_valid_in  = with_key;
    if (with_key) stored_key = key;
    step();
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    plain_text    = ~pt;
    cipher_key    = ~key;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 30) begin
      step();
      cycles++;
      if (data_valid_out) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_valid_in = 1'b0;
    key_valid_in = 1'b0;
    plain_text = '0;
    cipher_key = '0;
    stored_key = '0;
    step(); step();
    checks++;
    if (data_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", data_valid_out);
    end
    checks++;
    if (cipher_text !== 128'h0) begin
      errors++; $display("FAIL reset_ct: got %h expected 0", cipher_text);
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if (data_valid_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid: got %b expected 0", data_valid_out);
    end
  endtask

  task automatic test_fips_b();
    int cyc;
    logic [127:0] exp_ct;
    exp_ct = 128'h3925841d02dc09fbdc118597196a0b32;
    start_enc(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++; $display("FAIL fips_b_latency: got %0d expected 10", cyc);
    end
    checks++;
    if (cipher_text !== exp_ct) begin
      errors++; $display("FAIL fips_b_ct: got %h expected %h", cipher_text, exp_ct);
    end
    step();
    checks++;
    if (data_valid_out !== 1'b0) begin
      errors++; $display("FAIL fips_b_pulse_width: got %b expected 0", data_valid_out);
    end
    checks++;
    if (cipher_text !== exp_ct) begin
      errors++; $display("FAIL fips_b_hold: got %h expected %h", cipher_text, exp_ct);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] exp1, exp2;
    exp1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp2 = 128'h29c3505f571420f6402299b31a02d73a;
    start_enc(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    wait_done(cyc);
    checks++;
    if (cipher_text !== exp1 || cyc !== 10) begin
      errors++; $display("FAIL fips_c1_ct: got %h after %0d cycles expected %h after 10", cipher_text, cyc, exp1);
    end
    start_enc(128'h54776f204f6e65204e696e652054776f, 128'h5468617473206d79204b756e67204675, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 10", cyc);
    end
    checks++;
    if (cipher_text !== exp2) begin
      errors++; $display("FAIL b2b_ct: got %h expected %h", cipher_text, exp2);
    end
    step();
  endtask

  task automatic test_swapped();
    int cyc;
    logic [127:0] k, p, exp_ct;
    logic wk;
    k = 128'h00112233445566778899aabbccddeeff;
    p = 128'h000102030405060708090a0b0c0d0e0f;
    exp_ct = aes_model(k, p);
    start_enc(p, k, 1'b1);
    wait_done(cyc);
    checks++;
    if (cipher_text !== exp_ct || cyc !== 10) begin
      errors++; $display("FAIL swapped_ct: got %h after %0d expected %h", cipher_text, cyc, exp_ct);
    end
    step();
    p = rand128();
    exp_ct = aes_model(k, p);
    start_enc(p, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0);
    wait_done(cyc);
    checks++;
    if (cipher_text !== exp_ct) begin
      errors++; $display("FAIL stored_key_ct: got %h expected %h", cipher_text, exp_ct);
    end
    for (int n = 0; n < 6; n++) begin
      k  = rand128();
      p  = rand128();
      wk = (n % 3 != 1);
      exp_ct = aes_model(wk ? k : stored_key, p);
      start_enc(p, k, wk);
      wait_done(cyc);
      checks++;
      if (cipher_text !== exp_ct || cyc !== 10) begin
        errors++; $display("FAIL random_ct[%0d]: got %h after %0d expected %h", n, cipher_text, cyc, exp_ct);
      end
      if (n % 2 == 0) step();
    end
  endtask

  task automatic test_busy();
    logic [127:0] k, p, prev_ct, exp_ct;
    int pulses, pulse_cyc;
    bit held;
    k = rand128();
    p = rand128();
    prev_ct = cipher_text;
    exp_ct = aes_model(k, p);
    step();
    start_enc(p, k, 1'b1);
    pulses = 0;
    pulse_cyc = -1;
    held = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        data_valid_in = 1'b1;
        key_valid_in  = 1'b1;
        plain_text    = rand128();
        cipher_key    = rand128();
      end
      step();
      data_valid_in = 1'b0;
      key_valid_in  = 1'b0;
      if (data_valid_out) begin
        pulses++;
        pulse_cyc = c;
        checks++;
        if (cipher_text !== exp_ct) begin
          errors++; $display("FAIL busy_ct: got %h expected %h", cipher_text, exp_ct);
        end
      end else if (pulses == 0 && cipher_text !== prev_ct) begin
        held = 1'b0;
      end
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL busy_hold: ct changed during RUN, expected %h", prev_ct);
    end
    checks++;
    if (pulses !== 1 || pulse_cyc !== 10) begin
      errors++; $display("FAIL busy_pulses: got %0d pulses at %0d expected 1 at 10", pulses, pulse_cyc);
    end
    p = rand128();
    exp_ct = aes_model(k, p);
    start_enc(p, 128'h0, 1'b0);
    wait_done(pulse_cyc);
    checks++;
    if (cipher_text !== exp_ct) begin
      errors++; $display("FAIL busy_key_kept: got %h expected %h", cipher_text, exp_ct);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [127:0] k, p, exp_ct;
    int cyc;
    bit quiet;
    k = rand128();
    p = rand128();
    start_enc(p, k, 1'b1);
    for (int c = 0; c < 5; c++) step();
    reset = 1'b1;
    #1;
    checks++;
    if (data_valid_out !== 1'b0 || cipher_text !== 128'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b/%h expected 0/0", data_valid_out, cipher_text);
    end
    stored_key = '0;
    step();
    reset = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (data_valid_out !== 1'b0 || cipher_text !== 128'h0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL mid_reset_quiet: got %b/%h expected 0/0", data_valid_out, cipher_text);
    end
    p = rand128();
    exp_ct = aes_model(128'h0, p);
    start_enc(p, k, 1'b0);
    wait_done(cyc);
    checks++;
    if (cipher_text !== exp_ct) begin
      errors++; $display("FAIL mid_reset_zero_key: got %h expected %h", cipher_text, exp_ct);
    end
    exp_ct = aes_model(k, p);
    start_enc(p, k, 1'b1);
    wait_done(cyc);
    checks++;
    if (cipher_text !== exp_ct || cyc !== 10) begin
      errors++; $display("FAIL mid_reset_recover: got %h after %0d expected %h", cipher_text, cyc, exp_ct);
    end
  endtask

  initial begin
    reset = 1'b1;
    init_sbox();
    test_reset();
    test_fips_b();
    test_back_to_back();
    test_swapped();
    test_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
